// File: rtl/sha1_search_ctrl_pkg.sv
// Shared definitions for the SHA1 search job sequencer: nonce geometry,
// controller state encoding and the single-digit BCD adder.
package sha1_search_ctrl_pkg;

    localparam int NONCE_DIGITS = 15;
    localparam int NONCE_W      = 4 * NONCE_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    // Returns {carry, digit}; inputs are assumed to be valid BCD digits.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'd9) begin
            return {1'b1, 4'(s - 5'd10)};
        end
        return {1'b0, s[3:0]};
    endfunction

endpackage

// File: rtl/sha1_search_ctrl_bcd_add_const.sv
// Combinational addition of a small constant (one BCD digit) to a multi-digit
// BCD value, with decimal carry rippling through every digit.
module bcd_add_const
    import sha1_search_ctrl_pkg::*;
#(
    parameter int DIGITS = NONCE_DIGITS
) (
    input  logic [4*DIGITS-1:0] value_i,
    input  logic [3:0]          addend_i,
    output logic [4*DIGITS-1:0] sum_o,
    output logic                carry_o
);

    logic       c;
    logic [4:0] r;

    always_comb begin
        c     = 1'b0;
        r     = '0;
        sum_o = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r = bcd_digit_add(value_i[4*d +: 4], (d == 0) ? addend_i : 4'd0, c);
            sum_o[4*d +: 4] = r[3:0];
            c = r[4];
        end
        carry_o = c;
    end

endmodule

// File: rtl/sha1_search_ctrl.sv
// Multi-lane SHA1 search job sequencer: issues BCD base nonces, tracks them
// through the fixed hash latency and reports one found/exhausted result per job.
module sha1_search_ctrl
    import sha1_search_ctrl_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int PIPE_LATENCY = 82
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [NONCE_W-1:0] job_start,
    input  logic [NONCE_W-1:0] job_end,
    input  logic               abort,
    output logic [NONCE_W-1:0] tx_nonce,
    output logic               tx_nonce_valid,
    input  logic [LANES-1:0]   rx_match,
    output logic               result_valid,
    output logic               result_found,
    output logic [NONCE_W-1:0] result_nonce,
    input  logic               result_ack,
    output logic [NONCE_W-1:0] progress_nonce
);

    state_e state_q, state_d;
    logic [NONCE_W-1:0] base_q, base_d, end_q, end_d, retire_q, retire_d;
    logic [NONCE_W-1:0] progress_q, progress_d, res_nonce_q, res_nonce_d;
    logic               res_found_q, res_found_d;
    logic [PIPE_LATENCY-1:0] pipe_q, pipe_d, pipe_shift;

    logic [NONCE_W-1:0] base_next, retire_next, hit_nonce;
    logic               base_cy, retire_cy, issue, retired, active, hit;
    logic [NONCE_W-1:0] lane_nonce [LANES];
    logic [LANES-1:0]   lane_cy, lane_ok, lane_hit;

    assign active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign issue   = (state_q == ST_RUN);
    assign retired = pipe_q[PIPE_LATENCY-1];

    bcd_add_const #(.DIGITS(NONCE_DIGITS)) u_issue_step (
        .value_i(base_q), .addend_i(4'(LANES)), .sum_o(base_next), .carry_o(base_cy)
    );

    bcd_add_const #(.DIGITS(NONCE_DIGITS)) u_retire_step (
        .value_i(retire_q), .addend_i(4'(LANES)), .sum_o(retire_next), .carry_o(retire_cy)
    );

    // A lane past job_end (or past the top of the nonce space) never qualifies.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bcd_add_const #(.DIGITS(NONCE_DIGITS)) u_lane (
            .value_i(retire_q), .addend_i(4'(l)), .sum_o(lane_nonce[l]), .carry_o(lane_cy[l])
        );
        assign lane_ok[l] = retired && active && !lane_cy[l] && (lane_nonce[l] <= end_q);
    end

    assign lane_hit = rx_match & lane_ok;
    assign hit      = |lane_hit;

    always_comb begin
        hit_nonce = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_hit[l]) hit_nonce = lane_nonce[l];
        end
    end

    always_comb begin
        pipe_shift    = '0;
        pipe_shift[0] = issue;
        for (int i = 1; i < PIPE_LATENCY; i++) pipe_shift[i] = pipe_q[i-1];
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        end_d       = end_q;
        retire_d    = retire_q;
        progress_d  = progress_q;
        res_found_d = res_found_q;
        res_nonce_d = res_nonce_q;
        pipe_d      = pipe_shift;

        // Hold at the top of the nonce space instead of wrapping to zero.
        if (active && retired) begin
            progress_d = retire_q;
            if (!retire_cy) retire_d = retire_next;
        end

        case (state_q)
            ST_IDLE: begin
                if (job_valid) begin
                    base_d   = job_start;
                    end_d    = job_end;
                    retire_d = job_start;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pipe_d  = '0;
                end else if (hit) begin
                    state_d     = ST_REPORT;
                    res_found_d = 1'b1;
                    res_nonce_d = hit_nonce;
                    pipe_d      = '0;
                end else if (state_q == ST_RUN) begin
                    base_d = base_next;
                    if (base_cy || (base_next > end_q)) state_d = ST_DRAIN;
                end else if (pipe_shift == '0) begin
                    state_d     = ST_REPORT;
                    res_found_d = 1'b0;
                    res_nonce_d = end_q;
                end
            end
            ST_REPORT: begin
                if (result_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            end_q       <= '0;
            retire_q    <= '0;
            progress_q  <= '0;
            res_found_q <= 1'b0;
            res_nonce_q <= '0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            end_q       <= end_d;
            retire_q    <= retire_d;
            progress_q  <= progress_d;
            res_found_q <= res_found_d;
            res_nonce_q <= res_nonce_d;
            pipe_q      <= pipe_d;
        end
    end

    assign job_ready      = (state_q == ST_IDLE);
    assign tx_nonce_valid = issue;
    assign tx_nonce       = base_q;
    assign result_valid   = (state_q == ST_REPORT);
    assign result_found   = res_found_q;
    assign result_nonce   = res_nonce_q;
    assign progress_nonce = progress_q;

endmodule

// File: tb/tb_sha1_search_ctrl.sv
// Directed bench for sha1_search_ctrl with LANES=2, PIPE_LATENCY=4.
module tb_sha1_search_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [59:0] job_start;
    logic [59:0] job_end;
    logic        abort;
    logic [59:0] tx_nonce;
    logic        tx_nonce_valid;
    logic [1:0]  rx_match;
    logic        result_valid;
    logic        result_found;
    logic [59:0] result_nonce;
    logic        result_ack;
    logic [59:0] progress_nonce;

    int checks = 0;
    int errors = 0;

    sha1_search_ctrl #(.LANES(2), .PIPE_LATENCY(4)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_start(job_start), .job_end(job_end), .abort(abort),
        .tx_nonce(tx_nonce), .tx_nonce_valid(tx_nonce_valid), .rx_match(rx_match),
        .result_valid(result_valid), .result_found(result_found),
        .result_nonce(result_nonce), .result_ack(result_ack),
        .progress_nonce(progress_nonce)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [59:0] s, input logic [59:0] e);
        job_start = s;
        job_end   = e;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (job_ready !== 1'b1 || tx_nonce_valid !== 1'b0 || result_valid !== 1'b0 ||
            result_found !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b txv=%b rv=%b found=%b expected 1 0 0 0",
                     job_ready, tx_nonce_valid, result_valid, result_found);
        end
        checks++;
        if (tx_nonce !== 60'h0 || result_nonce !== 60'h0 || progress_nonce !== 60'h0) begin
            errors++;
            $display("FAIL reset_data: tx=%h res=%h prog=%h expected all 0",
                     tx_nonce, result_nonce, progress_nonce);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_exhausted();
        logic [59:0] exp_tx [5] = '{60'h100, 60'h102, 60'h104, 60'h106, 60'h108};
        start_job(60'h100, 60'h109);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_nonce_valid !== 1'b1 || tx_nonce !== exp_tx[i]) begin
                errors++;
                $display("FAIL exh_issue%0d: txv=%b tx=%h expected 1 %h",
                         i, tx_nonce_valid, tx_nonce, exp_tx[i]);
            end
            tick();
        end
        checks++;
        if (tx_nonce_valid !== 1'b0) begin
            errors++;
            $display("FAIL exh_drain_txv: got %b expected 0", tx_nonce_valid);
        end
        tick(); tick(); tick();
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL exh_early_result: got %b expected 0", result_valid);
        end
        tick();
        checks++;
        if (result_valid !== 1'b1 || result_found !== 1'b0 || result_nonce !== 60'h109) begin
            errors++;
            $display("FAIL exh_result: rv=%b found=%b nonce=%h expected 1 0 109",
                     result_valid, result_found, result_nonce);
        end
        ack_result();
        checks++;
        if (job_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL exh_ack: ready=%b rv=%b expected 1 0", job_ready, result_valid);
        end
    endtask

    task automatic test_found();
        start_job(60'h100, 60'h109);
        for (int i = 0; i < 6; i++) tick();
        rx_match = 2'b10;
        tick();
        rx_match = 2'b00;
        checks++;
        if (result_valid !== 1'b1 || result_found !== 1'b1 || result_nonce !== 60'h105 ||
            tx_nonce_valid !== 1'b0) begin
            errors++;
            $display("FAIL found_result: rv=%b found=%b nonce=%h txv=%b expected 1 1 105 0",
                     result_valid, result_found, result_nonce, tx_nonce_valid);
        end
        ack_result();
    endtask

    task automatic test_lane_mask();
        start_job(60'h100, 60'h104);
        for (int i = 0; i < 6; i++) tick();
        rx_match = 2'b10;
        tick();
        rx_match = 2'b00;
        checks++;
        if (result_valid !== 1'b1 || result_found !== 1'b0 || result_nonce !== 60'h104) begin
            errors++;
            $display("FAIL mask_result: rv=%b found=%b nonce=%h expected 1 0 104",
                     result_valid, result_found, result_nonce);
        end
        ack_result();
    endtask

    task automatic test_abort();
        int seen;
        start_job(60'h100, 60'h109);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (job_ready !== 1'b1 || tx_nonce_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: ready=%b txv=%b expected 1 0", job_ready, tx_nonce_valid);
        end
        seen = 0;
        rx_match = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (result_valid !== 1'b0) seen++;
        end
        rx_match = 2'b00;
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_result: result_valid seen %0d cycles expected 0", seen);
        end
        start_job(60'h200, 60'h203);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (result_valid !== 1'b1 || result_found !== 1'b0 || result_nonce !== 60'h203) begin
            errors++;
            $display("FAIL abort_next_job: rv=%b found=%b nonce=%h expected 1 0 203",
                     result_valid, result_found, result_nonce);
        end
        ack_result();
    endtask

    task automatic test_bcd_carry();
        logic [59:0] exp_seq [3] = '{60'h098, 60'h100, 60'h102};
        start_job(60'h098, 60'h103);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_nonce_valid !== 1'b1 || tx_nonce !== exp_seq[i]) begin
                errors++;
                $display("FAIL bcd_issue%0d: txv=%b tx=%h expected 1 %h",
                         i, tx_nonce_valid, tx_nonce, exp_seq[i]);
            end
            tick();
        end
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (progress_nonce !== exp_seq[i]) begin
                errors++;
                $display("FAIL bcd_progress%0d: got %h expected %h",
                         i, progress_nonce, exp_seq[i]);
            end
            if (i < 2) tick();
        end
        checks++;
        if (result_valid !== 1'b1 || result_found !== 1'b0 || result_nonce !== 60'h103) begin
            errors++;
            $display("FAIL bcd_result: rv=%b found=%b nonce=%h expected 1 0 103",
                     result_valid, result_found, result_nonce);
        end
        ack_result();
    endtask

    task automatic test_ack_hold();
        start_job(60'h300, 60'h309);
        for (int i = 0; i < 5; i++) tick();
        rx_match = 2'b11;
        tick();
        rx_match = 2'b00;
        result_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (result_valid !== 1'b1 || result_found !== 1'b1 || result_nonce !== 60'h302) begin
                errors++;
                $display("FAIL hold_cycle%0d: rv=%b found=%b nonce=%h expected 1 1 302",
                         i, result_valid, result_found, result_nonce);
            end
            tick();
        end
        ack_result();
        checks++;
        if (job_ready !== 1'b1 || result_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_ack: ready=%b rv=%b expected 1 0", job_ready, result_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        start_job(60'h500, 60'h599);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (job_ready !== 1'b1 || tx_nonce_valid !== 1'b0 || tx_nonce !== 60'h0 ||
            progress_nonce !== 60'h0) begin
            errors++;
            $display("FAIL midrst_state: ready=%b txv=%b tx=%h prog=%h expected 1 0 0 0",
                     job_ready, tx_nonce_valid, tx_nonce, progress_nonce);
        end
        seen = 0;
        rx_match = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (result_valid !== 1'b0) seen++;
        end
        rx_match = 2'b00;
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_result: result_valid seen %0d cycles expected 0", seen);
        end
    endtask

    initial begin
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_start  = '0;
        job_end    = '0;
        abort      = 1'b0;
        rx_match   = 2'b00;
        result_ack = 1'b0;
        test_reset();
        test_exhausted();
        test_found();
        test_lane_mask();
        test_abort();
        test_bcd_carry();
        test_ack_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha1_search_ctrl.md
Name: sha1_search_ctrl

Overview:
Job sequencer for the multi-lane SHA1 collision search. It accepts a search job (BCD nonce range), issues one base nonce per cycle to the LANES parallel expand_message/sha1 lanes, and tracks in-flight work across the fixed hash pipeline latency. Per-lane match flags are attributed back to the exact nonce. It reports one result per job (found/exhausted) via a valid/ack handshake. It replaces the free-running counter plus golden_nonce register in the top level.

Parameters:
LANES, 2, lanes hashed per cycle; lane l hashes base nonce + l (BCD); also the base nonce step.
PIPE_LATENCY, 82, cycles from tx_nonce issue to the matching rx_match sample; must be >= 1.
NONCE_DIGITS, 15, BCD digits in a nonce; nonce width = 4*NONCE_DIGITS.

Ports:
clk  in  1  hash clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
job_valid  in  1  job request.
job_ready  out  1  high only in IDLE.
job_start  in  60  first nonce, BCD.
job_end  in  60  last nonce to hash (inclusive), BCD; job_end >= job_start.
abort  in  1  cancel current job; no result is reported.
tx_nonce  out  60  base nonce to lanes.
tx_nonce_valid  out  1  tx_nonce is a live issue this cycle.
rx_match  in  LANES  per-lane hash==target, aligned PIPE_LATENCY cycles after issue.
result_valid  out  1  result pending.
result_found  out  1  1 = collision, 0 = range exhausted.
result_nonce  out  60  winning nonce (found) or job_end (exhausted).
result_ack  in  1  consumes result.
progress_nonce  out  60  base nonce of the most recently retired issue; for host monitoring.

Behaviour:
- States: IDLE, RUN, DRAIN, REPORT. Reset: state IDLE, job_ready=1, tx_nonce_valid=0, result_valid=0, result_found=0, tx_nonce/result_nonce/progress_nonce=0, in-flight delay line cleared.
- IDLE: on job_valid, capture start/end, go RUN. First tx_nonce_valid is in cycle T+1, with tx_nonce=job_start.
- RUN: one issue per cycle. Next base = base + LANES (BCD, per-digit carry, no A–F digits). Unsigned compare of BCD values is order-correct. If the next base > job_end, the current issue is the last and the block goes to DRAIN.
- In-flight tracking: a PIPE_LATENCY-deep 1-bit valid delay line, with no nonce storage. A retire nonce register starts at job_start and steps +LANES on each retired valid. progress_nonce follows it.
- Lane qualification: rx_match[l] counts only when the retired valid is set, state is RUN or DRAIN, and retire_nonce + l <= job_end. Lanes past the end are masked.
- Any qualified match: result_nonce = retire_nonce + lowest matching l, result_found=1, go REPORT. tx_nonce_valid is low from the next cycle. Remaining in-flight bits are flushed.
- DRAIN: no issues. When the delay line is empty and there is no qualified match, set result_found=0, result_nonce=job_end, go REPORT.
- A match on the same cycle as the last issue, or on the final retire, is still reported as found.
- REPORT: result_valid is held high with stable data until result_ack; then IDLE (job_ready=1 next cycle). result_ack outside REPORT is ignored.
- abort in RUN/DRAIN: go IDLE next cycle, flush the delay line, no result. abort beats a same-cycle match. Later rx_match pulses are ignored because the valid bits are cleared. abort in IDLE/REPORT is ignored.
- rst mid-operation returns to the reset state regardless of in-flight work.
- Timing: for issue at cycle t, the match is sampled at t+PIPE_LATENCY and result_valid rises at t+PIPE_LATENCY+1.

Decomposition:
- Shared package: NONCE_W (=4*NONCE_DIGITS), state encoding, and a BCD digit-add function.
- One sub-module, bcd_add_const: combinational add of a small constant (0..LANES) to a NONCE_DIGITS BCD value. It is instantiated for the issue step, the retire step, and per-lane qualification.

Test Plan:
1. LANES=2, PIPE_LATENCY=4, range 0x100..0x109, no match -> issues 0x100,0x102,0x104,0x106,0x108 on consecutive cycles; result_valid found=0, nonce=0x109 at 5 cycles after the last issue.
2. Same range, rx_match=2'b10 on the retire of 0x104 -> result_found=1, result_nonce=0x105; tx_nonce_valid drops the following cycle.
3. Range 0x100..0x104, rx_match=2'b10 on the retire of 0x104 (lane nonce 0x105 is masked) -> found=0, result_nonce=0x104.
4. abort on the 3rd RUN cycle, then rx_match=2'b11 pulses for 6 cycles -> no result_valid, job_ready=1 the cycle after abort; the next job (0x200..0x203) completes normally.
5. Start 0x0098 -> issue sequence 0x0098, 0x0100; never 0x009A. progress_nonce follows the same BCD sequence.
6. rx_match=2'b11 on one retire, result_ack withheld 5 cycles -> lowest lane reported; result_valid and data stable all 5 cycles; IDLE the cycle after ack.
